// File: rtl/jzjpcc_fetch.sv
// jzjpcc_fetch: fetch stage and IF/ID pipeline register of the pipelined RV32I core.
// Drives a synchronous-read instruction memory (data returns one cycle after the
// address) and presents {instruction, PC, PC+4, valid} to decode.
// A one-entry hold buffer keeps the memory word that arrives during a stall.
// Optional build macro: JZJPCC_FETCH_MISALIGN_TRAP_EN adds fetchHalted, a sticky
// halt raised by a redirect whose target has bit 1 set.
module jzjpcc_fetch #(
    parameter logic [31:0] RESET_VECTOR    = 32'h00000000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        pcRedirect,
    input  logic [31:0] pcRedirectTarget,
    output logic [29:0] instrMemAddr,
    input  logic [31:0] instrMemData,
    output logic [31:0] decodeInstruction,
    output logic [31:0] decodePC,
    output logic [31:0] decodePCPlus4,
`ifdef JZJPCC_FETCH_MISALIGN_TRAP_EN
    output logic        fetchHalted,
`endif
    output logic        decodeValid
);

    // Fetch-side state
    logic [31:0] r_pcF;
    logic [31:0] r_pcPending;
    logic        r_pendingValid;
    logic [31:0] r_holdData;
    logic        r_holdValid;

    // IF/ID register
    logic [31:0] r_decInstr;
    logic [31:0] r_decPC;
    logic [31:0] r_decPCPlus4;
    logic        r_decValid;

    // Word-aligned redirect target; the low bits are masked off here so the
    // redirect path never sees them.
    logic [31:0] w_target;
    logic [29:0] w_addrLive;

    assign w_target   = {pcRedirectTarget[31:2], pcRedirectTarget[1:0] & 2'b00};
    assign w_addrLive = pcRedirect ? w_target[31:2] : r_pcF[31:2];

`ifdef JZJPCC_FETCH_MISALIGN_TRAP_EN
    logic        r_halted;
    logic [29:0] r_lastAddr;
    logic        w_haltNow;

    // Only bit 1 traps; bit 0 is always cleared by JALR so it stays ignored.
    assign w_haltNow   = pcRedirect & pcRedirectTarget[1];
    assign fetchHalted = r_halted;

    // Remember the last address presented so it can be held while halted
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_halted   <= 1'b0;
            r_lastAddr <= '0;
        end else if (!r_halted) begin
            r_halted   <= w_haltNow;
            r_lastAddr <= w_addrLive;
        end
    end

    // Instruction memory address: frozen once halted, otherwise live
    always_comb begin
        instrMemAddr = w_addrLive;
        if (r_halted) begin
            instrMemAddr = r_lastAddr;
        end
    end
`else
    // Instruction memory address: redirect target takes effect in the same cycle
    always_comb begin
        instrMemAddr = w_addrLive;
    end
`endif

    // Fetch PC, pending-fetch tracking, hold buffer and IF/ID register update
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pcF          <= RESET_VECTOR;
            r_pcPending    <= '0;
            r_pendingValid <= 1'b0;
            r_holdData     <= '0;
            r_holdValid    <= 1'b0;
            r_decInstr     <= NOP_INSTRUCTION;
            r_decPC        <= '0;
            r_decPCPlus4   <= 32'd4;
            r_decValid     <= 1'b0;
        end
`ifdef JZJPCC_FETCH_MISALIGN_TRAP_EN
        else if (r_halted || w_haltNow) begin
            // Halted: pcF frozen, nothing in flight, decode sees bubbles only
            r_pendingValid <= 1'b0;
            r_holdValid    <= 1'b0;
            r_decInstr     <= NOP_INSTRUCTION;
            r_decValid     <= 1'b0;
        end
`endif
        else if (pcRedirect) begin
            // The redirect address is issued this cycle, so its data lands one
            // edge later: exactly one bubble, and anything held is stale.
            r_decInstr     <= NOP_INSTRUCTION;
            r_decValid     <= 1'b0;
            r_holdValid    <= 1'b0;
            r_pcPending    <= w_target;
            r_pendingValid <= 1'b1;
            r_pcF          <= w_target + 32'd4;
        end else if (stall) begin
            // Memory keeps being fed pcF, so the word for pcPending is only on
            // the bus during the first stall cycle; capture it then.
            if (r_pendingValid && !r_holdValid) begin
                r_holdData  <= instrMemData;
                r_holdValid <= 1'b1;
            end
        end else begin
            if (r_pendingValid) begin
                r_decInstr <= r_holdValid ? r_holdData : instrMemData;
            end else begin
                r_decInstr <= NOP_INSTRUCTION;
            end
            r_decPC        <= r_pcPending;
            r_decPCPlus4   <= r_pcPending + 32'd4;
            r_decValid     <= r_pendingValid;
            r_holdValid    <= 1'b0;
            r_pcPending    <= r_pcF;
            r_pendingValid <= 1'b1;
            r_pcF          <= r_pcF + 32'd4;
        end
    end

    assign decodeInstruction = r_decInstr;
    assign decodePC          = r_decPC;
    assign decodePCPlus4     = r_decPCPlus4;
    assign decodeValid       = r_decValid;

endmodule

// File: tb/tb_jzjpcc_fetch.sv
// Testbench for jzjpcc_fetch: directed scenarios followed by random
// stall/redirect/reset traffic, compared against a queue-based model of which
// instruction decode should see on each edge. A second instance checks PC wrap.
module tb_jzjpcc_fetch;

    localparam logic [31:0] RV  = 32'h00000000;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] RV2 = 32'hFFFFFFF8;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Main DUT signals
    logic        reset;
    logic        stall;
    logic        pcRedirect;
    logic [31:0] pcRedirectTarget;
    logic [29:0] instrMemAddr;
    logic [31:0] instrMemData;
    logic [31:0] decodeInstruction;
    logic [31:0] decodePC;
    logic [31:0] decodePCPlus4;
    logic        decodeValid;

    // Wrap-test DUT signals
    logic        reset2;
    logic [29:0] instrMemAddr2;
    logic [31:0] instrMemData2;
    logic [31:0] decodeInstruction2;
    logic [31:0] decodePC2;
    logic [31:0] decodePCPlus42;
    logic        decodeValid2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    function automatic logic [31:0] memf(input logic [29:0] w);
        return 32'h00100093 + {2'b00, w};
    endfunction

    jzjpcc_fetch #(.RESET_VECTOR(RV), .NOP_INSTRUCTION(NOP)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .pcRedirect(pcRedirect), .pcRedirectTarget(pcRedirectTarget),
        .instrMemAddr(instrMemAddr), .instrMemData(instrMemData),
        .decodeInstruction(decodeInstruction), .decodePC(decodePC),
        .decodePCPlus4(decodePCPlus4),
`ifdef JZJPCC_FETCH_MISALIGN_TRAP_EN
        .fetchHalted(),
`endif
        .decodeValid(decodeValid)
    );

    jzjpcc_fetch #(.RESET_VECTOR(RV2), .NOP_INSTRUCTION(NOP)) dut_wrap (
        .clock(clock), .reset(reset2), .stall(1'b0),
        .pcRedirect(1'b0), .pcRedirectTarget(32'h0),
        .instrMemAddr(instrMemAddr2), .instrMemData(instrMemData2),
        .decodeInstruction(decodeInstruction2), .decodePC(decodePC2),
        .decodePCPlus4(decodePCPlus42),
`ifdef JZJPCC_FETCH_MISALIGN_TRAP_EN
        .fetchHalted(),
`endif
        .decodeValid(decodeValid2)
    );

    // Synchronous-read instruction memories
    always @(posedge clock) begin
        instrMemData  <= memf(instrMemAddr);
        instrMemData2 <= memf(instrMemAddr2);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: m_inflight holds PCs issued to memory but not yet seen by
    // decode; m_next is the next sequential PC to issue.
    logic [31:0] m_inflight[$];
    logic [31:0] m_next    = RV;
    logic        m_valid   = 1'b0;
    logic        m_pcKnown = 1'b0;
    logic [31:0] m_pc      = '0;
    logic        m_started = 1'b0;

    task automatic model_step(input logic rst_n, input logic st, input logic rd, input logic [31:0] tg);
        logic [31:0] t;
        t = {tg[31:2], 2'b00};
        if (!rst_n) begin
            m_inflight.delete();
            m_next    = RV;
            m_valid   = 1'b0;
            m_pcKnown = 1'b1;
            m_pc      = 32'h0;
            m_started = 1'b1;
        end else if (rd) begin
            m_inflight.delete();
            m_inflight.push_back(t);
            m_next    = t + 32'd4;
            m_valid   = 1'b0;
            m_pcKnown = 1'b0;
        end else if (!st) begin
            if (m_inflight.size() > 0) begin
                m_pc      = m_inflight.pop_front();
                m_valid   = 1'b1;
                m_pcKnown = 1'b1;
            end else begin
                m_valid   = 1'b0;
                m_pcKnown = 1'b0;
            end
            m_inflight.push_back(m_next);
            m_next = m_next + 32'd4;
        end
    endtask

    // One clock: drive inputs after a falling edge, check the address, let the
    // rising edge happen, then check the IF/ID outputs at the next falling edge.
    task automatic do_cycle(input logic rst_n, input logic st, input logic rd, input logic [31:0] tg);
        logic [29:0] expAddr;
        reset            = rst_n;
        stall            = st;
        pcRedirect       = rd;
        pcRedirectTarget = tg;
        #1;
        if (rst_n && m_started) begin
            expAddr = rd ? tg[31:2] : m_next[31:2];
            check_eq("instrMemAddr", {2'b00, instrMemAddr}, {2'b00, expAddr});
        end
        @(posedge clock);
        model_step(rst_n, st, rd, tg);
        @(negedge clock);
        check_eq("decodeValid", {31'b0, decodeValid}, {31'b0, m_valid});
        check_eq("decodeInstruction", decodeInstruction, m_valid ? memf(m_pc[31:2]) : NOP);
        if (m_pcKnown) begin
            check_eq("decodePC", decodePC, m_pc);
            check_eq("decodePCPlus4", decodePCPlus4, m_pc + 32'd4);
        end
    endtask

    initial begin
        logic rst_n;
        logic st;
        logic rd;
        reset            = 1'b0;
        reset2           = 1'b0;
        stall            = 1'b0;
        pcRedirect       = 1'b0;
        pcRedirectTarget = '0;
        @(negedge clock);

        // Reset and start-up: PCs 0, 4, 8 reach decode
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        // Stall three cycles at decodePC=8, then release
        repeat (3) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (2) do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        // Redirect to 0x100 (low bits set to show they are ignored)
        do_cycle(1'b1, 1'b0, 1'b1, 32'h00000103);
        repeat (3) do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        // Stall builds up a held word, then stall+redirect to 0x40
        repeat (2) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h00000040);
        repeat (3) do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        // Reset while stalled with the hold buffer full, then restart
        repeat (2) do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (4) do_cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            rd    = ($urandom_range(0, 9) == 0);
            st    = ($urandom_range(0, 2) == 0);
            do_cycle(rst_n, st, rd, $urandom);
        end

        // Wrap: FFFFFFF8, FFFFFFFC, 00000000
        reset      = 1'b1;
        stall      = 1'b0;
        pcRedirect = 1'b0;
        reset2     = 1'b0;
        @(negedge clock);
        check_eq("wrap_reset_valid", {31'b0, decodeValid2}, 32'h0);
        check_eq("wrap_reset_pc4", decodePCPlus42, 32'd4);
        reset2 = 1'b1;
        @(negedge clock);
        check_eq("wrap_e1_valid", {31'b0, decodeValid2}, 32'h0);
        @(negedge clock);
        check_eq("wrap_e2_valid", {31'b0, decodeValid2}, 32'h1);
        check_eq("wrap_e2_pc", decodePC2, 32'hFFFFFFF8);
        check_eq("wrap_e2_instr", decodeInstruction2, 32'h00100093 + 32'h3FFFFFFE);
        @(negedge clock);
        check_eq("wrap_e3_pc", decodePC2, 32'hFFFFFFFC);
        check_eq("wrap_e3_pc4", decodePCPlus42, 32'h00000000);
        check_eq("wrap_e3_instr", decodeInstruction2, 32'h00100093 + 32'h3FFFFFFF);
        @(negedge clock);
        check_eq("wrap_e4_valid", {31'b0, decodeValid2}, 32'h1);
        check_eq("wrap_e4_pc", decodePC2, 32'h00000000);
        check_eq("wrap_e4_pc4", decodePCPlus42, 32'h00000004);
        check_eq("wrap_e4_instr", decodeInstruction2, 32'h00100093);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jzjpcc_fetch.md
Name: jzjpcc_fetch

Overview:
- Fetch stage plus IF/ID pipeline register of the pipelined RV32I core.
- Holds the fetch PC and drives the synchronous-read instruction memory, which returns data one cycle after the address.
- Presents {instruction, PC, PC+4, valid} to the decode stage, where the instruction feeds the immediate former and opcode decode.
- Accepts stall from the hazard unit and PC redirects from decode (JAL, JALR, taken BRANCH). Includes a one-entry hold buffer so memory data is not lost during stalls.

Parameters:
- RESET_VECTOR, 32'h00000000, byte address of the first fetch; bits [1:0] must be 0.
- NOP_INSTRUCTION, 32'h00000013, encoding driven on decodeInstruction when decodeValid=0.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hold the IF/ID register and the fetch PC this cycle.
- pcRedirect  in  1  decode requests a PC change this cycle.
- pcRedirectTarget  in  32  new byte PC, valid when pcRedirect=1.
- instrMemAddr  out  30  word address [31:2] presented to instruction memory this cycle.
- instrMemData  in  32  instruction for the address presented on the previous cycle.
- decodeInstruction  out  32  IF/ID instruction.
- decodePC  out  32  PC of decodeInstruction.
- decodePCPlus4  out  32  decodePC+4, modulo 2^32.
- decodeValid  out  1  IF/ID contents are a real instruction; 0 means bubble.

Behaviour:
- State:
  - pcF: address being issued.
  - pcPending, pendingValid: the address issued last cycle, whose data is arriving now.
  - holdData, holdValid: the hold buffer.
  - the IF/ID registers.
- Reset (reset=0 at an edge):
  - pcF=RESET_VECTOR; pendingValid=0; holdValid=0; pcPending=0.
  - decodeValid=0, decodeInstruction=NOP_INSTRUCTION, decodePC=0, decodePCPlus4=4.
  - Reset mid-operation discards all in-flight fetches.
- instrMemAddr (combinational) = pcRedirect ? pcRedirectTarget[31:2] : pcF[31:2].
- Priority: reset > pcRedirect > stall > normal.
- Normal cycle (no redirect, no stall), at the edge:
  - IF/ID instruction <= holdValid ? holdData : instrMemData.
  - decodePC <= pcPending; decodeValid <= pendingValid; holdValid <= 0.
  - pcPending <= pcF; pendingValid <= 1; pcF <= pcF+4 (wraps 32'hFFFFFFFC -> 0).
- Stall cycle (no redirect):
  - IF/ID, pcF, pcPending and pendingValid hold.
  - If pendingValid=1 and holdValid=0: holdData <= instrMemData, holdValid <= 1. This captures data only on the first stall cycle.
  - Memory keeps receiving pcF, so its data is correct on the first cycle after the stall releases.
- Redirect cycle (stall ignored):
  - IF/ID <= bubble (decodeValid=0, NOP); holdValid <= 0.
  - pcPending <= {target[31:2],2'b00}; pendingValid <= 1; pcF <= {target[31:2],2'b00}+4.
  - Penalty is exactly one bubble cycle.
- Throughput: one instruction per cycle when unstalled.
- Latency: 2 edges from address issue to decodeValid.
- First valid instruction (RESET_VECTOR) appears 2 edges after reset deasserts.
- decodePCPlus4 is registered alongside decodePC; it is never computed combinationally from the output.
- Bits [1:0] of pcRedirectTarget are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: JZJPCC_FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port fetchHalted (1 bit, reset 0).
  - A redirect with pcRedirectTarget[1]=1 sets fetchHalted sticky until reset.
  - While halted: decodeValid is forced to 0 every edge, pcF freezes, pendingValid=0, and instrMemAddr holds the last value.
  - Target[0] is still ignored, since JALR clears it.
- Undefined: no port; target[1:0] is forced to 00 silently.

Test Plan:
- Reset release with RESET_VECTOR=0, memory[i]=32'h00100093+i:
  - decodeValid rises on the 2nd edge with decodePC=0, decodePCPlus4=4.
  - Then PCs 4, 8, 12 follow on consecutive edges.
- Stall held 3 cycles while decodePC=8:
  - decodePC stays 8.
  - After release, the next edges give PCs 12 then 16 with the correct data; no duplicate or dropped instruction.
- pcRedirect with target 32'h00000100 while decodePC=8:
  - The next edge gives a bubble (decodeValid=0, NOP 32'h00000013).
  - The following edge gives decodePC=32'h100.
- Stall and pcRedirect (target 32'h40) asserted together:
  - The redirect wins: one bubble, then decodePC=32'h40.
  - Hold buffer contents are discarded.
- Wrap: RESET_VECTOR=32'hFFFFFFF8 gives decodePCs FFFFFFF8, FFFFFFFC, 00000000 in order, with decodePCPlus4 for FFFFFFFC = 0.
- Reset asserted during a stall with holdValid=1:
  - The next edge gives decodeValid=0.
  - After release, fetch restarts at RESET_VECTOR.
  - With JZJPCC_FETCH_MISALIGN_TRAP_EN defined, a redirect to 32'h102 sets fetchHalted=1 and keeps decodeValid=0 until reset.
